keypad_scanner: RTL
===================

# keypad_scanner

Scans a 4x4 active-low matrix keypad, synchronizes and debounces the row inputs, and converts key presses into the game's answer interface. It sits directly upstream of the game top: `digit` drives its `keypad_input`, and `check_answer` drives its active-low `check_answer`. Digits 0-9 set the displayed answer, `*` clears it to 0, `#` submits it, and A-D are ignored.

## Interface
- `SCAN_CYCLES`, default 12000: clk cycles each column is driven (1 ms at 12 MHz); must be >= 4.
- `DEBOUNCE_SCANS`, default 20: identical consecutive full-scan snapshots required before the debounced state updates; must be >= 2.
- `clk` input 1: system clock (12 MHz domain).
- `reset` input 1: synchronous, active-high.
- `rows` input 4: keypad rows, asynchronous, pulled up; low = key closed on the driven column.
- `cols` output 4: column drive, one-cold; low = driven.
- `digit` output 4: current answer value, always 0-9.
- `digit_valid` output 1: one-cycle pulse whenever `digit` is written.
- `check_answer` output 1: active-low; low while `#` is held (debounced).

## Operation
- Key map, row r / column c:
  - row 0: 1 2 3 A
  - row 1: 4 5 6 B
  - row 2: 7 8 9 C
  - row 3: * 0 # D
- `rows` passes through a 2-flop synchronizer before any use.
- Scan counter:
  - `col_idx` 0..3 advances every SCAN_CYCLES cycles, wrapping 3 -> 0.
  - `cols = ~(4'b1 << col_idx)`.
- On the last dwell cycle of each column, store `~rows_sync` into snapshot bits `[4*col_idx +: 4]`.
- Scan end is the last dwell cycle of column 3. At scan end:
  - Compare the completed 16-bit snapshot with the previous snapshot.
  - Equal: `stable_cnt` increments, saturating at DEBOUNCE_SCANS-1.
  - Not equal: `stable_cnt` clears to 0.
- When `stable_cnt` reaches DEBOUNCE_SCANS-1, load `deb_keys` from the snapshot.
- Press events are `deb_keys & ~deb_keys_prev`, evaluated on the cycle after a `deb_keys` update:
  - Exactly one new key that is 0-9: `digit` takes its value and `digit_valid` pulses.
  - Exactly one new key that is `*`: `digit` becomes 0 and `digit_valid` pulses.
  - `#`, A-D, or two or more new keys in the same update: `digit` unchanged, no pulse.
- `check_answer = ~deb_keys[#]`, registered.
  - `#` held together with other keys still drives `check_answer` low.
- Releases generate no events.
- A key held indefinitely generates exactly one event.

## Timing
- Reset values:
  - `cols` = 4'b1110, `col_idx` = 0, dwell counter = 0.
  - `digit` = 0, `digit_valid` = 0, `check_answer` = 1.
  - snapshot, previous snapshot, `deb_keys` and `stable_cnt` all = 0.
- Scan period is 4*SCAN_CYCLES cycles.
- Synchronizer delay (2 cycles) is less than the dwell time, so each sample is taken after the column has settled.
- Press latency:
  - First full scan containing the key: scan end E.
  - `deb_keys` updates at scan end E + (DEBOUNCE_SCANS-1) scans, provided every intervening snapshot is identical.
  - `digit`, `digit_valid` and `check_answer` change 1 cycle after that update.
- Any bounce in a scan restarts the count from 0.
- Reset asserted mid-scan: all state returns to reset values on the next clock edge and scanning restarts at column 0. A key held through reset is re-detected as a new press.
- Consecutive presses of the same digit each produce a pulse, provided a release is debounced between them.

## Structure
- Package `keypad_pkg` holds:
  - localparam key index constants KEY_STAR = 12, KEY_HASH = 14, KEY_A..KEY_D;
  - a `key_value(idx)` function returning the 4-bit digit for indices 0-9 and `*`.
- Sub-module `sync_2ff`: a width-parameterised 2-flop synchronizer instantiated for `rows`.
  - The same module is reused for the game's other asynchronous inputs.
- Everything else is a single always_ff with a combinational event decode.

## Test plan
All scenarios run with SCAN_CYCLES=4 and DEBOUNCE_SCANS=3 (scan period 16 cycles).
- Reset then idle (rows = 4'hF) for 200 cycles -> `cols` cycles 1110, 1101, 1011, 0111 every 4 cycles; `digit` = 0; `check_answer` = 1; no pulses.
- Hold key 7 (row 2 low while `cols` = 1110) -> exactly one `digit_valid`, `digit` = 7, 1 cycle after the third identical scan end; no further pulse while held.
- Key 5 with row toggling every other scan for 6 scans, then stable -> no event during bouncing; a single pulse with `digit` = 5 after 3 stable scans.
- Press 8, release, then press `*` -> `digit` 8 then 0; two pulses total.
- Hold `#` -> `check_answer` goes low after debounce, stays low while held, and returns high after the debounced release; `digit` unchanged.
- 1 and 2 pressed in the same scan -> no event. Reset asserted mid-scan -> outputs return to reset values on the next edge.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared key indices and key decoding for the 4x4 keypad scanner.
// Key index is row-major: idx = 4*row + col.
package keypad_pkg;

    localparam int NUM_KEYS = 16;

    localparam int KEY_A    = 3;
    localparam int KEY_B    = 7;
    localparam int KEY_C    = 11;
    localparam int KEY_STAR = 12;
    localparam int KEY_HASH = 14;
    localparam int KEY_D    = 15;

    // Value written to the answer for a key; '*' clears to 0.
    function automatic logic [3:0] key_value(input logic [3:0] idx);
        logic [3:0] val;
        case (idx)
            4'd0:    val = 4'd1;
            4'd1:    val = 4'd2;
            4'd2:    val = 4'd3;
            4'd4:    val = 4'd4;
            4'd5:    val = 4'd5;
            4'd6:    val = 4'd6;
            4'd8:    val = 4'd7;
            4'd9:    val = 4'd8;
            4'd10:   val = 4'd9;
            4'd13:   val = 4'd0;
            default: val = 4'd0;
        endcase
        return val;
    endfunction

    // Keys that write the answer: digits 0-9 and '*'.
    function automatic logic key_is_entry(input logic [3:0] idx);
        logic hit;
        case (idx)
            4'd0, 4'd1, 4'd2, 4'd4, 4'd5, 4'd6,
            4'd8, 4'd9, 4'd10, 4'd12, 4'd13: hit = 1'b1;
            default:                         hit = 1'b0;
        endcase
        return hit;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Width-parameterised two-flop synchronizer for asynchronous inputs.
module sync_2ff #(
    parameter int               WIDTH     = 1,
    parameter logic [WIDTH-1:0] RESET_VAL = '0
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] meta_q, meta_d;
    logic [WIDTH-1:0] sync_q, sync_d;

    // Shift the input through two stages.
    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    // Synchronizer flops.
    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: column scan, snapshot debounce, press-event
// decode into the answer digit and the active-low check_answer strobe.
import keypad_pkg::*;

module keypad_scanner #(
    parameter int SCAN_CYCLES    = 12000,  // dwell per column, >= 4
    parameter int DEBOUNCE_SCANS = 20      // identical scans required, >= 2
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] rows,
    output logic [3:0] cols,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       check_answer
);

    localparam int DW = (SCAN_CYCLES > 1) ? $clog2(SCAN_CYCLES) : 1;
    localparam int CW = $clog2(DEBOUNCE_SCANS);
    localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_CYCLES - 1);
    localparam logic [CW-1:0] STABLE_MAX = CW'(DEBOUNCE_SCANS - 1);

    logic [3:0]    rows_sync;
    logic [DW-1:0] dwell_q, dwell_d;
    logic [1:0]    col_idx_q, col_idx_d;
    logic [15:0]   snap_q, snap_d;           // column-major: bit 4*col + row
    logic [15:0]   prev_snap_q, prev_snap_d;
    logic [CW-1:0] stable_cnt_q, stable_cnt_d;
    logic [15:0]   deb_keys_q, deb_keys_d;   // row-major key index
    logic [15:0]   deb_prev_q, deb_prev_d;
    logic [3:0]    digit_q, digit_d;
    logic          digit_valid_q, digit_valid_d;
    logic          check_answer_q, check_answer_d;

    logic          last_dwell;
    logic          scan_end;
    logic [3:0]    col_sample;
    logic [15:0]   snap_upd;   // snapshot including this cycle's column sample
    logic [15:0]   snap_keys;  // snap_upd re-ordered into key-index order
    logic [15:0]   new_keys;
    logic [4:0]    new_count;
    logic [3:0]    new_idx;

    // Rows are pulled up, so the idle synchronizer value is all ones.
    sync_2ff #(
        .WIDTH     (4),
        .RESET_VAL (4'hF)
    ) u_rows_sync (
        .clk   (clk),
        .reset (reset),
        .d     (rows),
        .q     (rows_sync)
    );

    assign last_dwell = (dwell_q == DWELL_LAST);
    assign scan_end   = last_dwell && (col_idx_q == 2'd3);

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_col
            assign col_sample[gi]      = last_dwell && (col_idx_q == 2'(gi));
            assign snap_upd[4*gi +: 4] = col_sample[gi] ? ~rows_sync : snap_q[4*gi +: 4];
        end
        for (genvar gi = 0; gi < 4; gi++) begin : g_row
            for (genvar gj = 0; gj < 4; gj++) begin : g_key
                assign snap_keys[4*gi + gj] = snap_upd[4*gj + gi];
            end
        end
    endgenerate

    assign new_keys = deb_keys_q & ~deb_prev_q;

    // Count the newly pressed keys and locate one of them.
    always_comb begin
        new_count = '0;
        new_idx   = '0;
        for (int i = 0; i < NUM_KEYS; i++) begin
            if (new_keys[i]) begin
                new_count = new_count + 5'd1;
                new_idx   = 4'(i);
            end
        end
    end

    // Next-state: scan counters, debounce and event decode.
    always_comb begin
        dwell_d        = last_dwell ? '0 : dwell_q + DW'(1);
        col_idx_d      = last_dwell ? col_idx_q + 2'd1 : col_idx_q;
        snap_d         = snap_upd;
        prev_snap_d    = prev_snap_q;
        stable_cnt_d   = stable_cnt_q;
        deb_keys_d     = deb_keys_q;
        deb_prev_d     = deb_keys_q;
        digit_d        = digit_q;
        digit_valid_d  = 1'b0;
        check_answer_d = ~deb_keys_q[KEY_HASH];

        if (scan_end) begin
            prev_snap_d = snap_upd;
            if (snap_upd == prev_snap_q) begin
                stable_cnt_d = (stable_cnt_q == STABLE_MAX) ? STABLE_MAX
                                                            : stable_cnt_q + CW'(1);
            end else begin
                stable_cnt_d = '0;
            end
            if (stable_cnt_d == STABLE_MAX) begin
                deb_keys_d = snap_keys;
            end
        end

        // Only a lone new digit or '*' writes the answer.
        if ((new_count == 5'd1) && key_is_entry(new_idx)) begin
            digit_d       = key_value(new_idx);
            digit_valid_d = 1'b1;
        end
    end

    // State registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            dwell_q        <= '0;
            col_idx_q      <= '0;
            snap_q         <= '0;
            prev_snap_q    <= '0;
            stable_cnt_q   <= '0;
            deb_keys_q     <= '0;
            deb_prev_q     <= '0;
            digit_q        <= '0;
            digit_valid_q  <= 1'b0;
            check_answer_q <= 1'b1;
        end else begin
            dwell_q        <= dwell_d;
            col_idx_q      <= col_idx_d;
            snap_q         <= snap_d;
            prev_snap_q    <= prev_snap_d;
            stable_cnt_q   <= stable_cnt_d;
            deb_keys_q     <= deb_keys_d;
            deb_prev_q     <= deb_prev_d;
            digit_q        <= digit_d;
            digit_valid_q  <= digit_valid_d;
            check_answer_q <= check_answer_d;
        end
    end

    assign cols         = ~(4'b0001 << col_idx_q);
    assign digit        = digit_q;
    assign digit_valid  = digit_valid_q;
    assign check_answer = check_answer_q;

endmodule
